// File: rtl/ifu_fetch.sv
// Instruction fetch front end: issues in-order imem requests, buffers responses in a
// small queue and presents the head to IDU0, with redirect flush and in-flight discard.
module ifu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        pipe_stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_tag
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] discard_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   tag_q  [FIFO_DEPTH];

    logic queue_credit;
    logic flight_credit;
    logic req_fire;
    logic push;
    logic pop;

    // A request is only issued when its response is guaranteed a queue slot,
    // so a push can never meet a full queue even while IDU0 is stalled.
    assign queue_credit   = ({1'b0, count} + {1'b0, live_cnt}) < DEPTH_W;
    assign flight_credit  = ({1'b0, live_cnt} + {1'b0, discard_cnt}) < DEPTH_W;
    assign imem_req_valid = rst_n && queue_credit && flight_credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && (discard_cnt == '0) && !redirect_valid;
    assign pop  = instr_valid && !pipe_stall && !redirect_valid;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? data_q[rd_ptr] : NOP;
    assign instr_tag   = instr_valid ? tag_q[rd_ptr]  : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            count       <= '0;
            live_cnt    <= '0;
            discard_cnt <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still owed becomes garbage; a response arriving now is one of them.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            live_cnt    <= '0;
            discard_cnt <= discard_cnt + live_cnt - CW'(imem_rsp_valid);
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            live_cnt <= live_cnt + CW'(req_fire) - CW'(push);
            if (imem_rsp_valid && (discard_cnt != '0))
                discard_cnt <= discard_cnt - CW'(1);
        end
    end

    // Queue payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rsp_data;
            tag_q[wr_ptr]  <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a behavioural instruction memory plus a scoreboard of
// accepted fetch addresses that every IDU0 consumption is compared against.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pipe_stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_tag;

    logic        rsp_hold;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [31:0] pending [$];

    ifu_fetch #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pipe_stall     (pipe_stall),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_tag      (instr_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            smp();
            n++;
        end
        chk(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    // Instruction memory model and consumption scoreboard
    initial begin
        logic        acc;
        logic        r;
        logic [31:0] a;
        logic [31:0] e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            r   = rst_n;
            acc = rst_n && imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (redirect_valid) begin
                    sb.delete();
                end else if (instr_valid && !pipe_stall) begin
                    chk("sb_nonempty", {31'b0, (sb.size() > 0)}, 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("pop_tag", instr_tag, e);
                        chk("pop_data", instr, memf(e));
                    end
                end
                if (acc)
                    sb.push_back(a);
            end
            @(posedge clk);
            #2;
            if (!r) begin
                pending.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (acc)
                    pending.push_back(a);
                if (!rsp_hold && pending.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(pending.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] h;
        logic [31:0] a;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pipe_stall     = 1'b0;
        rsp_hold       = 1'b0;

        // Reset state
        smp();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_tag", instr_tag, 32'h0);
        drv();
        rst_n = 1'b1;
        smp();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Streaming with no gaps
        wait_valid("stream_wait", 10);
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", {31'b0, instr_valid}, 32'd1);
            chk("stream_tag", instr_tag, 32'(4 * i));
            chk("stream_data", instr, memf(32'(4 * i)));
            smp();
        end

        // Stall for 10 cycles: queue fills, requests stop, head holds
        drv();
        pipe_stall = 1'b1;
        smp();
        h = instr_tag;
        repeat (9) smp();
        chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_head", instr_tag, h);
        drv();
        pipe_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("unstall_tag", instr_tag, h + 32'(4 * k));
        end

        // Redirect with two requests in flight
        drv();
        imem_req_ready = 1'b0;
        repeat (8) smp();
        chk("drain_empty", {31'b0, instr_valid}, 32'd0);
        drv();
        rsp_hold       = 1'b1;
        imem_req_ready = 1'b1;
        smp();
        chk("hold_req0", {31'b0, imem_req_valid}, 32'd1);
        drv();
        smp();
        chk("hold_req1", {31'b0, imem_req_valid}, 32'd1);
        drv();
        imem_req_ready = 1'b0;
        smp();
        chk("hold_no_rsp", {31'b0, instr_valid}, 32'd0);
        drv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        imem_req_ready = 1'b1;
        smp();
        chk("redir1_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        drv();
        redirect_valid = 1'b0;
        rsp_hold       = 1'b0;
        smp();
        chk("redir1_n1_empty", {31'b0, instr_valid}, 32'd0);
        chk("redir1_n1_addr", imem_req_addr, 32'h0000_0100);
        wait_valid("redir1_wait", 20);
        chk("redir1_tag", instr_tag, 32'h0000_0100);
        chk("redir1_data", instr, memf(32'h0000_0100));

        // Redirect coinciding with a response and a pop
        repeat (6) smp();
        drv();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #2;
        chk("redir2_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
        chk("redir2_pop_present", {31'b0, instr_valid}, 32'd1);
        smp();
        chk("redir2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        drv();
        redirect_valid = 1'b0;
        smp();
        chk("redir2_n1_empty", {31'b0, instr_valid}, 32'd0);
        chk("redir2_n1_nop", instr, NOP);
        chk("redir2_n1_tag", instr_tag, 32'h0);
        wait_valid("redir2_wait", 20);
        chk("redir2_tag", instr_tag, 32'h0000_0200);
        chk("redir2_data", instr, memf(32'h0000_0200));

        // Memory back-pressure: request held stable
        repeat (4) smp();
        drv();
        imem_req_ready = 1'b0;
        smp();
        a = imem_req_addr;
        chk("bp_valid", {31'b0, imem_req_valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("bp_valid_hold", {31'b0, imem_req_valid}, 32'd1);
            chk("bp_addr_hold", imem_req_addr, a);
        end
        drv();
        imem_req_ready = 1'b1;
        smp();
        chk("bp_resume_addr", imem_req_addr, a);
        smp();
        chk("bp_next_addr", imem_req_addr, a + 32'd4);
        repeat (8) smp();

        // Reset with entries buffered and a request in flight
        drv();
        pipe_stall = 1'b1;
        smp();
        smp();
        drv();
        rst_n = 1'b0;
        smp();
        chk("rst2_req_gated", {31'b0, imem_req_valid}, 32'd0);
        drv();
        rst_n      = 1'b1;
        pipe_stall = 1'b0;
        smp();
        chk("rst2_empty", {31'b0, instr_valid}, 32'd0);
        chk("rst2_nop", instr, NOP);
        chk("rst2_tag", instr_tag, 32'h0);
        chk("rst2_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rst2_req_addr", imem_req_addr, 32'h0);
        wait_valid("rst2_wait", 10);
        chk("rst2_first_tag", instr_tag, 32'h0);
        chk("rst2_first_data", instr, memf(32'h0));
        repeat (6) smp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
